qft_phase_sched: RTL and testbench

//  Sequencer for the controlled-phase half of a QFT on an N-qubit state vector.
//  - Holds 2^N complex amplitudes in an internal buffer.
//  - Walks every (target, control) qubit pair and streams each matching amplitude through an external combinational complex rotation multiplier.
//  - Writes the rounded, saturated result back into the buffer.
//  - Sits between the host load/readback interface and the shared rotation multiplier.

---
 rtl/qft_pkg.sv | 10 +
 rtl/qft_phase_sched_if.sv | 24 ++
 rtl/qft_amp_conv.sv | 22 ++
 rtl/qft_phase_sched.sv | 102 ++++++++++
 tb/tb_qft_phase_sched.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/qft_pkg.sv
// qft_pkg: shared types, widths and rotation coefficients for the QFT phase scheduler
package qft_pkg;
  localparam int COEF_W = 12;
  localparam int PROD_W = 13;
  localparam int PROD_FRAC = 5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  // cos/sin(2*pi/2^k) in Q1.10, valid for k=2..6; other slots unused
  localparam logic signed [COEF_W-1:0] ROT_COS [8] = '{12'sd0, 12'sd0, 12'sd0, 12'sd724, 12'sd946, 12'sd1004, 12'sd1019, 12'sd0};
  localparam logic signed [COEF_W-1:0] ROT_SIN [8] = '{12'sd0, 12'sd0, 12'sd1024, 12'sd724, 12'sd392, 12'sd200, 12'sd100, 12'sd0};
endpackage

// File: rtl/qft_phase_sched_if.sv
// qft_phase_sched_if: host load/readback/control bus plus rotation multiplier bus
// master: host and external multiplier side; slave: the scheduler
interface qft_phase_sched_if import qft_pkg::*; #(
  parameter int N_QUBITS = 3,
  parameter int AMP_W = 8
);
  logic wr_en;
  logic [N_QUBITS-1:0] wr_addr;
  logic signed [AMP_W-1:0] wr_re, wr_im;
  logic [N_QUBITS-1:0] rd_addr;
  logic signed [AMP_W-1:0] rd_re, rd_im;
  logic start, busy, done;
  logic signed [AMP_W-1:0] mul_in_r, mul_in_i;
  logic signed [COEF_W-1:0] mul_cos, mul_sin;
  logic signed [PROD_W-1:0] mul_out_r, mul_out_i;
  modport master (
    output wr_en, wr_addr, wr_re, wr_im, rd_addr, start, mul_out_r, mul_out_i,
    input rd_re, rd_im, busy, done, mul_in_r, mul_in_i, mul_cos, mul_sin
  );
  modport slave (
    input wr_en, wr_addr, wr_re, wr_im, rd_addr, start, mul_out_r, mul_out_i,
    output rd_re, rd_im, busy, done, mul_in_r, mul_in_i, mul_cos, mul_sin
  );
endinterface

// File: rtl/qft_amp_conv.sv
// qft_amp_conv: Q7.5 product -> AMP_W integer, arithmetic shift then saturate
// i_x: signed PROD_W product; o_y: signed AMP_W amplitude
// QFT_ROUND_EN defined: add half an LSB before the shift (round half up); else floor
module qft_amp_conv import qft_pkg::*; #(
  parameter int AMP_W = 8
) (
  input  logic signed [PROD_W-1:0] i_x,
  output logic signed [AMP_W-1:0]  o_y
);
  localparam int MX = 2**(AMP_W-1) - 1;
  localparam int MN = -(2**(AMP_W-1));
  logic signed [PROD_W:0] w_sum, w_sh;
  logic signed [31:0] w_v;
`ifdef QFT_ROUND_EN
  assign w_sum = {i_x[PROD_W-1], i_x} + (PROD_W+1)'(1 << (PROD_FRAC-1));
`else
  assign w_sum = {i_x[PROD_W-1], i_x};
`endif
  assign w_sh = w_sum >>> PROD_FRAC;
  assign w_v = 32'(w_sh);
  assign o_y = w_v > MX ? AMP_W'(MX) : w_v < MN ? AMP_W'(MN) : AMP_W'(w_v);
endmodule

// File: rtl/qft_phase_sched.sv
// qft_phase_sched: controlled-phase half of a QFT over a 2^N_QUBITS amplitude buffer
// clk, rst: clock and synchronous active-high reset
// bus (slave): host load/readback, start/busy/done, and the external rotation multiplier
// QFT_ROUND_EN selects round-half-up conversion of multiplier results (default floor)
module qft_phase_sched import qft_pkg::*; #(
  parameter int N_QUBITS = 3,
  parameter int AMP_W = 8
) (
  input logic clk,
  input logic rst,
  qft_phase_sched_if.slave bus
);
  localparam int D = 2**N_QUBITS;
  localparam int P = N_QUBITS * (N_QUBITS - 1) / 2;
  localparam logic [2:0] T0 = 3'(N_QUBITS - 1);
  localparam logic [2:0] C0 = 3'(N_QUBITS - 2);
  state_t r_state;
  logic r_busy, r_done;
  logic [2:0] r_t, r_c;
  logic [N_QUBITS-1:0] r_i;
  logic signed [AMP_W-1:0] r_re [D];
  logic signed [AMP_W-1:0] r_im [D];
  logic signed [AMP_W-1:0] r_rd_re, r_rd_im;
  logic [N_QUBITS-1:0] w_tc;
  logic w_hit;
  logic [2:0] w_k;
  logic signed [AMP_W-1:0] w_cr, w_ci;
  // index i is rotated by pair (t,c) when both of its bits t and c are set
  assign w_tc = N_QUBITS'((1 << r_t) | (1 << r_c));
  assign w_hit = r_state == RUN && (r_i & w_tc) == w_tc;
  assign w_k = r_t - r_c + 3'd1;
  assign bus.mul_in_r = w_hit ? r_re[r_i] : '0;
  assign bus.mul_in_i = w_hit ? r_im[r_i] : '0;
  assign bus.mul_cos = w_hit ? ROT_COS[w_k] : '0;
  assign bus.mul_sin = w_hit ? ROT_SIN[w_k] : '0;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.rd_re = r_rd_re;
  assign bus.rd_im = r_rd_im;
  qft_amp_conv #(.AMP_W(AMP_W)) u_conv_r (.i_x(bus.mul_out_r), .o_y(w_cr));
  qft_amp_conv #(.AMP_W(AMP_W)) u_conv_i (.i_x(bus.mul_out_i), .o_y(w_ci));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_t <= '0;
      r_c <= '0;
      r_i <= '0;
      r_rd_re <= '0;
      r_rd_im <= '0;
      for (int j = 0; j < D; j++) begin
        r_re[j] <= '0;
        r_im[j] <= '0;
      end
    end else begin
      r_rd_re <= r_re[bus.rd_addr];
      r_rd_im <= r_im[bus.rd_addr];
      if (bus.wr_en && r_state != RUN) begin
        r_re[bus.wr_addr] <= bus.wr_re;
        r_im[bus.wr_addr] <= bus.wr_im;
      end
      if (w_hit) begin
        r_re[r_i] <= w_cr;
        r_im[r_i] <= w_ci;
      end
      case (r_state)
        IDLE: if (bus.start) begin
          // a single qubit has no pairs, so the run collapses straight to DONE
          if (P == 0) begin
            r_state <= DONE;
            r_done <= 1'b1;
          end else begin
            r_state <= RUN;
            r_busy <= 1'b1;
            r_t <= T0;
            r_c <= C0;
            r_i <= '0;
          end
        end
        RUN: begin
          r_i <= r_i + 1'b1;
          if (&r_i) begin
            if (r_c != 3'd0) r_c <= r_c - 3'd1;
            else if (r_t == 3'd1) begin
              r_state <= DONE;
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_t <= r_t - 3'd1;
              r_c <= r_t - 3'd2;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_qft_phase_sched.sv
// tb_qft_phase_sched: directed table-driven bench for qft_phase_sched (N=3 and N=1)
module tb_qft_phase_sched;
  typedef struct {int re; int im;} amp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass = 0;
  int total = 0;
  amp_t exp1 [8];
  amp_t exp3 [8];
  logic signed [31:0] pr, pi;
  qft_phase_sched_if #(.N_QUBITS(3), .AMP_W(8)) b3 ();
  qft_phase_sched_if #(.N_QUBITS(1), .AMP_W(8)) b1 ();
  qft_phase_sched #(.N_QUBITS(3), .AMP_W(8)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
  qft_phase_sched #(.N_QUBITS(1), .AMP_W(8)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  always #5 clk = ~clk;
  function automatic logic signed [12:0] sat13(input logic signed [31:0] v);
    return v > 4095 ? 13'sd4095 : v < -4096 ? 13'(-4096) : 13'(v);
  endfunction
  always_comb begin
    pr = (32'(b3.mul_in_r) * 32'(b3.mul_cos) - 32'(b3.mul_in_i) * 32'(b3.mul_sin)) >>> 5;
    pi = (32'(b3.mul_in_r) * 32'(b3.mul_sin) + 32'(b3.mul_in_i) * 32'(b3.mul_cos)) >>> 5;
    b3.mul_out_r = sat13(pr);
    b3.mul_out_i = sat13(pi);
  end
  assign b1.mul_out_r = '0;
  assign b1.mul_out_i = '0;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a !== e) $display("FAIL %s: got %0d want %0d", n, a, e);
    else pass++;
  endtask
  task automatic load(input int a, input int re, input int im);
    b3.wr_en = 1'b1;
    b3.wr_addr = 3'(a);
    b3.wr_re = 8'(re);
    b3.wr_im = 8'(im);
    tick;
    b3.wr_en = 1'b0;
  endtask
  task automatic rd(input int a, output int re, output int im);
    b3.rd_addr = 3'(a);
    tick;
    re = b3.rd_re;
    im = b3.rd_im;
  endtask
  task automatic check_buf(input string n, input amp_t e [8]);
    int re, im;
    for (int a = 0; a < 8; a++) begin
      rd(a, re, im);
      chk($sformatf("%s re[%0d]", n, a), re, e[a].re);
      chk($sformatf("%s im[%0d]", n, a), im, e[a].im);
    end
  endtask
  task automatic run(input bit cm, input int s1, input int s2, input int w, input int r,
                     output int bc, output int dc, output int bz);
    b3.start = 1'b1;
    tick;
    b3.start = 1'b0;
    b3.wr_en = 1'b0;
    bc = 0;
    while (b3.busy && bc < 200) begin
      if (cm && bc == 3) chk("mul_in_r idle idx", b3.mul_in_r, 0);
      if (cm && bc == 6) begin
        chk("mul_in_r k2", b3.mul_in_r, 64);
        chk("mul_cos k2", b3.mul_cos, 0);
        chk("mul_sin k2", b3.mul_sin, 1024);
      end
      if (cm && bc == 13) begin
        chk("mul_cos k3", b3.mul_cos, 724);
        chk("mul_sin k3", b3.mul_sin, 724);
      end
      b3.start = (bc == s1 || bc == s2);
      b3.wr_en = (bc == w);
      b3.wr_addr = 3'd0;
      b3.wr_re = 8'sd99;
      b3.wr_im = 8'sd99;
      rst = (bc == r);
      bc++;
      tick;
      b3.start = 1'b0;
      b3.wr_en = 1'b0;
      rst = 1'b0;
    end
    dc = b3.done;
    bz = 0;
    repeat (6) begin
      tick;
      dc += b3.done;
      bz += b3.busy;
    end
  endtask
  initial begin
    int bc, dc, bz, re, im;
    exp1 = '{'{64, 0}, '{64, 0}, '{64, 0}, '{0, 64}, '{64, 0}, '{45, 45}, '{0, 64}, '{-45, -45}};
`ifndef QFT_ROUND_EN
    exp1[7] = '{-45, -46};
`endif
    exp3 = '{'{0, 0}, '{0, 0}, '{0, 0}, '{0, 0}, '{0, 0}, '{0, 127}, '{0, 0}, '{0, 0}};
    {b3.wr_en, b3.start, b1.wr_en, b1.start} = '0;
    b3.wr_addr = '0; b3.wr_re = '0; b3.wr_im = '0; b3.rd_addr = '0;
    b1.wr_addr = '0; b1.wr_re = '0; b1.wr_im = '0; b1.rd_addr = '0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    chk("reset busy", b3.busy, 0);
    chk("reset done", b3.done, 0);
    chk("reset mul_in_r", b3.mul_in_r, 0);
    chk("reset mul_sin", b3.mul_sin, 0);
    chk("reset rd_re", b3.rd_re, 0);
    for (int a = 0; a < 7; a++) load(a, 64, 0);
    b3.wr_en = 1'b1;
    b3.wr_addr = 3'd7;
    b3.wr_re = 8'sd64;
    b3.wr_im = 8'sd0;
    run(1'b1, -1, -1, -1, -1, bc, dc, bz);
    chk("t1 busy cycles", bc, 24);
    chk("t1 done pulses", dc, 1);
    check_buf("t1", exp1);
    for (int a = 0; a < 8; a++) load(a, a == 5 ? 127 : 0, a == 5 ? 127 : 0);
    run(1'b0, -1, -1, -1, -1, bc, dc, bz);
    chk("t3 busy cycles", bc, 24);
    check_buf("t3", exp3);
    for (int a = 0; a < 8; a++) load(a, 64, 0);
    run(1'b0, 3, 10, 5, -1, bc, dc, bz);
    chk("t4 busy cycles", bc, 24);
    chk("t4 done pulses", dc, 1);
    chk("t4 no rerun", bz, 0);
    check_buf("t4", exp1);
    for (int a = 0; a < 8; a++) load(a, 64, 0);
    run(1'b0, -1, -1, -1, 12, bc, dc, bz);
    chk("t5 busy until rst", bc, 13);
    chk("t5 done pulses", dc, 0);
    chk("t5 busy after", bz, 0);
    for (int a = 0; a < 8; a++) begin
      rd(a, re, im);
      chk($sformatf("t5 cleared[%0d]", a), (re != 0 || im != 0) ? 1 : 0, 0);
    end
    b1.wr_en = 1'b1; b1.wr_addr = 1'b0; b1.wr_re = 8'sd10; b1.wr_im = -8'sd3;
    tick;
    b1.wr_addr = 1'b1; b1.wr_re = 8'sd7; b1.wr_im = 8'sd5;
    tick;
    b1.wr_en = 1'b0;
    b1.start = 1'b1;
    chk("t6 busy at start", b1.busy, 0);
    tick;
    b1.start = 1'b0;
    chk("t6 done", b1.done, 1);
    chk("t6 busy", b1.busy, 0);
    chk("t6 mul_in_r", b1.mul_in_r, 0);
    chk("t6 mul_cos", b1.mul_cos, 0);
    tick;
    chk("t6 done drop", b1.done, 0);
    chk("t6 busy after", b1.busy, 0);
    b1.rd_addr = 1'b0;
    tick;
    chk("t6 rd0 re", b1.rd_re, 10);
    chk("t6 rd0 im", b1.rd_im, -3);
    b1.rd_addr = 1'b1;
    tick;
    chk("t6 rd1 re", b1.rd_re, 7);
    chk("t6 rd1 im", b1.rd_im, 5);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
